axil_reg_responder: RTL and testbench
=====================================

# axil_reg_responder

AXI4-Lite slave register file for the robot controller IP: the responder that the AXI VIP master drives with single-beat AXI4-Lite writes and reads. It holds NUM_REGS 32-bit read/write registers. Their contents are exported to the controller core, together with a one-cycle write-strobe per register. Every write is readable back unchanged, subject to WSTRB, with OKAY response. Out-of-range addresses are answered with SLVERR.

## Interface
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 4, byte-address width; must be at least clog2(NUM_REGS)+2.
- NUM_REGS, 4, number of 32-bit registers, word-aligned from offset 0x0.
- ACLK  in  1  single clock.
- ARESETN  in  1  asynchronous assert, active-low reset; all state clears while low.
- S_AXI_AWADDR / AWPROT / AWVALID  in  ADDR_WIDTH / 3 / 1  write address; AWPROT is ignored.
- S_AXI_AWREADY  out  1  write-address accept.
- S_AXI_WDATA / WSTRB / WVALID  in  32 / 4 / 1  write data.
- S_AXI_WREADY  out  1  write-data accept.
- S_AXI_BRESP / BVALID  out  2 / 1  write response.
- S_AXI_BREADY  in  1.
- S_AXI_ARADDR / ARPROT / ARVALID  in  ADDR_WIDTH / 3 / 1  read address; ARPROT is ignored.
- S_AXI_ARREADY  out  1.
- S_AXI_RDATA / RRESP / RVALID  out  32 / 2 / 1  read data.
- S_AXI_RREADY  in  1.
- reg_q  out  NUM_REGS*32  register contents; register k occupies bits [32k+31:32k].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle register k is committed.

## Operation
- Word index is addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored. An index >= NUM_REGS is out of range.
- Write FSM states: W_IDLE, W_RESP.
  - AW and W are accepted independently, in either order or in the same cycle, into a one-deep AW buffer and a one-deep W buffer.
  - AWREADY is high while the AW buffer is empty and the FSM is in W_IDLE. WREADY follows the same rule for the W buffer.
  - When both buffers are full, the write commits. For each byte lane with WSTRB[b]=1, register[idx] byte b takes the new data. reg_wr_pulse[idx] pulses for one cycle. BVALID rises and the FSM enters W_RESP.
  - An out-of-range write leaves all registers untouched, does not pulse, and returns BRESP=2'b10. In-range writes return BRESP=2'b00.
  - WSTRB=0 is still a valid write: OKAY response, no data change, reg_wr_pulse still asserted.
  - BVALID stays high until BREADY. On the B handshake both buffers clear and the FSM returns to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - ARREADY is high only in R_IDLE.
  - On the AR handshake, RDATA is registered from register[idx] (0 if out of range), RRESP is 2'b00 or 2'b10, RVALID rises, and the FSM enters R_DATA.
  - RDATA and RRESP hold stable until RREADY, then the FSM returns to R_IDLE.
- Read and write paths are fully independent.
  - A read handshake in the same cycle as a write commit to the same register returns the old value. Read-during-write is not forwarded.
- Reset mid-transaction: all handshakes are abandoned immediately, with no response issued after release.

## Timing
- Reset values:
  - AWREADY=0, WREADY=0, ARREADY=0 while ARESETN=0. They go high on the first ACLK edge after release.
  - BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
  - reg_q=0 and reg_wr_pulse=0.
- Write latency:
  - If AW and W handshake in cycle n, BVALID, reg_q update and reg_wr_pulse all appear in cycle n+1.
  - If they arrive separately, the same events occur in the cycle after the later handshake.
- Read latency: an AR handshake in cycle n gives RVALID in cycle n+1.
- Throughput with BREADY/RREADY tied high: one write every 2 cycles and one read every 2 cycles.
- No combinational path from any VALID or READY input to any output.

## Structure
- Package axil_reg_pkg holds:
  - the RESP_OKAY (2'b00) and RESP_SLVERR (2'b10) constants;
  - the write-FSM and read-FSM state enums;
  - a byte-merge function taking (old, new, strb).
- Sub-module axil_reg_wr_ctrl contains the AW/W buffers and the write FSM, and produces commit, idx and out-of-range signals. The read path and register array stay in the top level.

## Test plan
- Sequential write/read: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back -> each read returns the matching value with RRESP=0. reg_wr_pulse fires once per write on indices 0..3.
- Channel ordering: present W three cycles before AW, then AW three cycles before W, targeting 0x4 -> BVALID appears one cycle after the later handshake. Both orders give identical results.
- Strobes: write 0xAABBCCDD to 0x8 with WSTRB=4'b1111, then 0x11223344 with WSTRB=4'b0101 -> read returns 0xAA22CC44.
- Out-of-range: write 0xDEADBEEF to 0x10, then read 0x10 -> BRESP=2'b10, RRESP=2'b10, RDATA=0. Registers 0..3 are unchanged and no reg_wr_pulse occurs.
- Backpressure: hold BREADY=0 and RREADY=0 for 10 cycles -> BVALID, RVALID, RDATA and BRESP stay stable throughout. AWREADY, WREADY and ARREADY stay low until the respective handshake completes.
- Reset mid-write: deassert ARESETN after the AW handshake but before W -> all outputs are 0 immediately. After release, the previously sent address is forgotten, and a fresh write to 0x0 behaves normally.

Source files
------------

// File: rtl/axil_reg_responder_pkg.sv
// ----------------------------------------------------------------------------
// axil_reg_pkg
// Shared definitions for the AXI4-Lite register responder:
//   RESP_OKAY / RESP_SLVERR  - AXI response codes
//   wr_state_t / rd_state_t  - write and read FSM state encodings
//   byte_merge()             - applies a 4-bit byte strobe to a 32-bit word
// ----------------------------------------------------------------------------
package axil_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Lanes with strb[b]=1 take the new byte, the rest keep the old byte.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg_responder_if.sv
// ----------------------------------------------------------------------------
// axil_reg_responder_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master modport : drives addresses, data, VALIDs and BREADY/RREADY
//   slave  modport : drives AWREADY/WREADY/ARREADY, B and R channel payloads
// Handshake rule on every channel: a transfer happens on the rising clock edge
// where VALID and READY are both high; the source holds VALID and payload
// stable until that edge, and READY may be asserted independently of VALID.
// ----------------------------------------------------------------------------
interface axil_reg_responder_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axil_reg_responder_wr_ctrl.sv
// ----------------------------------------------------------------------------
// axil_reg_wr_ctrl
// Write-side control: one-deep AW and W buffers plus the W_IDLE/W_RESP FSM.
//   i_awaddr/i_awvalid/o_awready  write address channel
//   i_wdata/i_wstrb/i_wvalid/o_wready  write data channel
//   o_bresp/o_bvalid/i_bready     write response channel
//   o_commit   high in the cycle the write is applied (both halves present)
//   o_idx/o_oor/o_data/o_strb  word index, out-of-range flag, payload
//   o_state    current FSM state (debug)
// ----------------------------------------------------------------------------
module axil_reg_wr_ctrl
  import axil_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4,
  parameter int IDX_W      = ADDR_WIDTH - 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_wstrb,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic                  o_commit,
  output logic [IDX_W-1:0]      o_idx,
  output logic                  o_oor,
  output logic [31:0]           o_data,
  output logic [3:0]            o_strb,
  output wr_state_t             o_state
);

  wr_state_t             r_state;
  logic                  r_aw_full;
  logic                  r_w_full;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_aw_have;
  logic                  w_w_have;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_oor;
  logic                  w_commit;
  logic                  w_unused_lsb;

  assign w_aw_hs   = i_awvalid & r_awready;
  assign w_w_hs    = i_wvalid  & r_wready;
  // A half counts as present if buffered earlier or arriving this cycle, so a
  // same-cycle AW+W pair commits on the handshake edge itself.
  assign w_aw_have = r_aw_full | w_aw_hs;
  assign w_w_have  = r_w_full  | w_w_hs;

  assign w_addr   = r_aw_full ? r_awaddr : i_awaddr;
  assign o_data   = r_w_full  ? r_wdata  : i_wdata;
  assign o_strb   = r_w_full  ? r_wstrb  : i_wstrb;
  assign w_idx    = w_addr[ADDR_WIDTH-1:2];
  assign w_oor    = (32'(w_idx) >= 32'(NUM_REGS));
  assign w_commit = (r_state == W_IDLE) & w_aw_have & w_w_have;
  assign w_unused_lsb = ^w_addr[1:0];

  assign o_commit  = w_commit;
  assign o_idx     = w_idx;
  assign o_oor     = w_oor;
  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;
  assign o_state   = r_state;

  // READYs are registered: they drop the cycle after their buffer fills and
  // rise again only after the B handshake, so they are 0 through reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= W_IDLE;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_awaddr  <= i_awaddr;
          end
          if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_wdata  <= i_wdata;
            r_wstrb  <= i_wstrb;
          end
          if (w_commit) begin
            r_state   <= W_RESP;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_oor ? RESP_SLVERR : RESP_OKAY;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
          end else begin
            r_awready <= ~w_aw_have;
            r_wready  <= ~w_w_have;
          end
        end
        W_RESP: begin
          if (i_bready) begin
            r_state   <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: r_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axil_reg_responder.sv
// ----------------------------------------------------------------------------
// axil_reg_responder
// AXI4-Lite slave holding NUM_REGS 32-bit read/write registers.
//   ACLK, ARESETN   clock and asynchronous active-low reset
//   s_axi           AXI4-Lite slave bus (AW/W/B/AR/R)
//   reg_q           register contents, register k at [32k+31:32k]
//   reg_wr_pulse    one-cycle pulse per register on each committed write
//   o_wr_state      write FSM state (debug)
//   o_rd_state      read FSM state (debug)
// ----------------------------------------------------------------------------
module axil_reg_responder
  import axil_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axil_reg_responder_if.slave            s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  output wr_state_t                      o_wr_state,
  output rd_state_t                      o_rd_state
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  logic                  w_commit;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_wr_oor;
  logic [31:0]           w_wr_data;
  logic [3:0]            w_wr_strb;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_rd_oor;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic                  w_unused;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;

  rd_state_t             r_rd_state;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  axil_reg_wr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr_ctrl (
    .i_clk     (ACLK),
    .i_rst_n   (ARESETN),
    .i_awaddr  (s_axi.S_AXI_AWADDR),
    .i_awvalid (s_axi.S_AXI_AWVALID),
    .o_awready (s_axi.S_AXI_AWREADY),
    .i_wdata   (s_axi.S_AXI_WDATA),
    .i_wstrb   (s_axi.S_AXI_WSTRB),
    .i_wvalid  (s_axi.S_AXI_WVALID),
    .o_wready  (s_axi.S_AXI_WREADY),
    .o_bresp   (s_axi.S_AXI_BRESP),
    .o_bvalid  (s_axi.S_AXI_BVALID),
    .i_bready  (s_axi.S_AXI_BREADY),
    .o_commit  (w_commit),
    .o_idx     (w_wr_idx),
    .o_oor     (w_wr_oor),
    .o_data    (w_wr_data),
    .o_strb    (w_wr_strb),
    .o_state   (o_wr_state)
  );

  // Protection bits and the byte offset within a word carry no meaning here.
  assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_ARADDR[1:0]};

  // Register array; an out-of-range commit touches nothing and does not pulse.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      r_wr_pulse <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_wr_pulse[k] <= 1'b0;
        if (w_commit && !w_wr_oor && (32'(w_wr_idx) == k)) begin
          r_regs[k]     <= byte_merge(r_regs[k], w_wr_data, w_wr_strb);
          r_wr_pulse[k] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end
  assign reg_wr_pulse = r_wr_pulse;

  // Read mux sees the pre-edge register value, so a read coinciding with a
  // write commit to the same register returns the old contents.
  assign w_rd_idx = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign w_rd_oor = (32'(w_rd_idx) >= 32'(NUM_REGS));

  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (32'(w_rd_idx) == k) w_rd_val = r_regs[k];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (s_axi.S_AXI_ARVALID && r_arready) begin
            r_rd_state <= R_DATA;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rdata    <= w_rd_oor ? '0 : w_rd_val;
            r_rresp    <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            r_rd_state <= R_IDLE;
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;
  assign o_rd_state          = r_rd_state;

endmodule

// File: tb/tb_axil_reg_responder.sv
// ----------------------------------------------------------------------------
// tb_axil_reg_responder
// Bench for axil_reg_responder: a vector table of writes/reads with
// hand-derived expected responses, plus sequences for channel ordering,
// backpressure, read-during-write and reset in the middle of a write.
// ----------------------------------------------------------------------------
module tb_axil_reg_responder;
  import axil_reg_pkg::*;

  localparam int AW = 8;
  localparam int NR = 4;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  axil_reg_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  logic [NR*32-1:0] reg_q;
  logic [NR-1:0]    reg_wr_pulse;
  wr_state_t        wr_state;
  rd_state_t        rd_state;

  axil_reg_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NR)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .s_axi        (bus),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse),
    .o_wr_state   (wr_state),
    .o_rd_state   (rd_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [31:0] mdl [NR];
  logic        bvalid_neg;

  // BVALID as seen in the middle of the previous cycle.
  always @(negedge ACLK) bvalid_neg = bus.S_AXI_BVALID;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: ready never asserted within cycle budget", name);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [127:0] mdl_packed();
    logic [127:0] res;
    res = '0;
    for (int k = 0; k < NR; k++) res[32*k +: 32] = mdl[k];
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_aw(input logic [AW-1:0] a, input int dly);
    int n;
    repeat (dly) tick();
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWPROT  = 3'($urandom_range(0, 7));
    bus.S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 50) begin tick(); n++; end
    if (!bus.S_AXI_AWREADY) timeout("awready");
    tick();
    bus.S_AXI_AWVALID = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n;
    repeat (dly) tick();
    bus.S_AXI_WDATA  = d;
    bus.S_AXI_WSTRB  = s;
    bus.S_AXI_WVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_WREADY && n < 50) begin tick(); n++; end
    if (!bus.S_AXI_WREADY) timeout("wready");
    tick();
    bus.S_AXI_WVALID = 1'b0;
  endtask

  task automatic drive_ar(input logic [AW-1:0] a);
    int n;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARPROT  = 3'($urandom_range(0, 7));
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin tick(); n++; end
    if (!bus.S_AXI_ARREADY) timeout("arready");
    tick();
    bus.S_AXI_ARVALID = 1'b0;
  endtask

  // Hold BREADY low for 'hold' cycles, then take the response and score it.
  task automatic collect_b(input int hold);
    logic [1:0] resp0;
    logic [1:0] got;
    int bad;
    resp0 = bus.S_AXI_BRESP;
    bad = 0;
    bus.S_AXI_BREADY = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== resp0 ||
          bus.S_AXI_AWREADY !== 1'b0 || bus.S_AXI_WREADY !== 1'b0) bad++;
    end
    if (hold > 0) check("b_backpressure_stable", bad, 0);
    bus.S_AXI_BREADY = 1'b1;
    got = bus.S_AXI_BRESP;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    if (exp_b_q.size() == 0) begin
      timeout("bresp_unexpected");
    end else begin
      check("bresp", got, exp_b_q.pop_front());
    end
    check("bvalid_cleared", bus.S_AXI_BVALID, 1'b0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input logic [1:0] resp, input int hold);
    int idx;
    logic [NR-1:0] exp_pulse;
    idx = int'(a[AW-1:2]);
    exp_b_q.push_back(resp);
    fork
      drive_aw(a, aw_dly);
      drive_w(d, s, w_dly);
    join
    // Now just after the later handshake edge: BVALID must have just risen.
    check("bvalid_latency", {bvalid_neg, bus.S_AXI_BVALID}, 2'b01);
    exp_pulse = '0;
    if (idx < NR) begin
      exp_pulse[idx] = 1'b1;
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    end
    check("reg_wr_pulse", reg_wr_pulse, exp_pulse);
    check("reg_q_after_write", reg_q, mdl_packed());
    collect_b(hold);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [1:0] resp, input logic [31:0] rdata,
                         input int hold);
    logic [33:0] v0;
    logic [33:0] got;
    int bad;
    exp_r_q.push_back({resp, rdata});
    drive_ar(a);
    check("rvalid_latency", bus.S_AXI_RVALID, 1'b1);
    v0 = {bus.S_AXI_RRESP, bus.S_AXI_RDATA};
    bad = 0;
    bus.S_AXI_RREADY = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.S_AXI_RVALID !== 1'b1 || {bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== v0 ||
          bus.S_AXI_ARREADY !== 1'b0) bad++;
    end
    if (hold > 0) check("r_backpressure_stable", bad, 0);
    bus.S_AXI_RREADY = 1'b1;
    got = {bus.S_AXI_RRESP, bus.S_AXI_RDATA};
    tick();
    bus.S_AXI_RREADY = 1'b0;
    if (exp_r_q.size() == 0) begin
      timeout("rdata_unexpected");
    end else begin
      check("rresp_rdata", got, exp_r_q.pop_front());
    end
    check("rvalid_cleared", bus.S_AXI_RVALID, 1'b0);
  endtask

  task automatic add(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [1:0] resp, input logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.resp = resp; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    for (int k = 0; k < NR; k++) mdl[k] = '0;

    // Vector table: {wr, addr, wdata, wstrb, expected resp, expected rdata}
    add(1, 8'h00, 32'h0000_0001, 4'hF, RESP_OKAY,   32'h0);
    add(1, 8'h04, 32'h0000_0002, 4'hF, RESP_OKAY,   32'h0);
    add(1, 8'h08, 32'h0000_0003, 4'hF, RESP_OKAY,   32'h0);
    add(1, 8'h0C, 32'h0000_0004, 4'hF, RESP_OKAY,   32'h0);
    add(0, 8'h00, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0001);
    add(0, 8'h04, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0002);
    add(0, 8'h08, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0003);
    add(0, 8'h0C, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0004);
    add(1, 8'h08, 32'hAABB_CCDD, 4'hF, RESP_OKAY,   32'h0);
    add(1, 8'h08, 32'h1122_3344, 4'h5, RESP_OKAY,   32'h0);
    add(0, 8'h08, 32'h0,         4'h0, RESP_OKAY,   32'hAA22_CC44);
    add(1, 8'h10, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR, 32'h0);
    add(0, 8'h10, 32'h0,         4'h0, RESP_SLVERR, 32'h0);
    add(0, 8'h00, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0001);
    add(0, 8'h04, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0002);
    add(0, 8'h0C, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0004);
    add(1, 8'h06, 32'hFFFF_FFFF, 4'h0, RESP_OKAY,   32'h0);
    add(0, 8'h05, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0002);
    add(1, 8'hFC, 32'h1234_5678, 4'hF, RESP_SLVERR, 32'h0);
    add(0, 8'h0E, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0004);

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
    check("rst_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    check("rst_resp_data", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, 36'h0);
    check("rst_reg_q", reg_q, '0);
    check("rst_pulse", reg_wr_pulse, '0);
    ARESETN = 1'b1;
    #1;
    check("release_readies_low", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
    tick();
    check("release_readies_high", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);

    // Table-driven transactions
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr[AW-1:0], vecs[i].data, vecs[i].strb, 0, 0, vecs[i].resp, 0);
      else            do_read(vecs[i].addr[AW-1:0], vecs[i].resp, vecs[i].rdata, 0);
    end

    // Channel ordering: W three cycles ahead of AW, then AW three cycles ahead of W
    do_write(8'h04, 32'h0BAD_0001, 4'hF, 3, 0, RESP_OKAY, 0);
    do_read(8'h04, RESP_OKAY, 32'h0BAD_0001, 0);
    do_write(8'h04, 32'h0BAD_0002, 4'hF, 0, 3, RESP_OKAY, 0);
    do_read(8'h04, RESP_OKAY, 32'h0BAD_0002, 0);

    // Backpressure: responses held 10 cycles
    do_write(8'h0C, 32'h7777_0077, 4'hF, 0, 0, RESP_OKAY, 10);
    do_read(8'h0C, RESP_OKAY, 32'h7777_0077, 10);
    do_read(8'h14, RESP_SLVERR, 32'h0, 10);

    // Read in the same cycle as a write commit to the same register sees the old value
    fork
      do_write(8'h00, 32'hCAFE_F00D, 4'hF, 0, 0, RESP_OKAY, 0);
      do_read(8'h00, RESP_OKAY, 32'h0000_0001, 0);
    join
    do_read(8'h00, RESP_OKAY, 32'hCAFE_F00D, 0);

    // Reset after AW handshake, before W
    drive_aw(8'h0C, 0);
    #2;
    ARESETN = 1'b0;
    #1;
    check("midrst_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
    check("midrst_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP}, 4'h0);
    check("midrst_reg_q", reg_q, '0);
    check("midrst_pulse", reg_wr_pulse, '0);
    for (int k = 0; k < NR; k++) mdl[k] = '0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    tick();
    drive_w(32'h1357_9BDF, 4'hF, 0);
    repeat (3) tick();
    check("midrst_aw_forgotten", {bus.S_AXI_BVALID, reg_wr_pulse}, '0);
    check("midrst_no_write", reg_q, '0);
    exp_b_q.push_back(RESP_OKAY);
    drive_aw(8'h00, 0);
    check("fresh_bvalid", bus.S_AXI_BVALID, 1'b1);
    check("fresh_pulse", reg_wr_pulse, 4'b0001);
    mdl[0] = 32'h1357_9BDF;
    check("fresh_reg_q", reg_q, mdl_packed());
    collect_b(0);
    do_read(8'h00, RESP_OKAY, 32'h1357_9BDF, 0);

    // Leftover expectations mean a response never arrived
    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_r_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
